// File: rtl/xor_frame_accumulator.sv
// xor_frame_accumulator
//   Streams WIDTH-bit beats over a valid/ready handshake and folds every beat
//   of a frame (terminated by in_last) into a bitwise XOR. For each frame it
//   produces the XOR, a parity bit of that XOR, and a saturating beat count,
//   all on a registered valid/ready output.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready drops only while a result is
//                     held because the sink is stalled
//   in_data, in_last  beat payload and end-of-frame marker
//   out_valid/ready   result handshake
//   out_xor           XOR of all beats in the frame
//   out_parity        XOR-reduce of out_xor, inverted when ODD != 0
//   out_beats         beats in the frame, saturating at 2^CNT_W-1
module xor_frame_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ODD   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic             ODD_BIT = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE,
    ACC
  } state_e;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] acc_q,        acc_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_xor_q,    out_xor_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_beats_q,  out_beats_d;

  logic             accept;
  logic [WIDTH-1:0] beat_xor;
  logic [CNT_W-1:0] beat_cnt;

  // Accept unless a result is stuck waiting for the sink; a result being
  // drained this cycle frees the output slot for a new final beat.
  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  // Frame totals including the beat on the input. A beat seen in IDLE starts
  // a fresh frame, so the accumulator and counter are not consulted there.
  always_comb begin
    if (state_q == IDLE) begin
      beat_xor = in_data;
      beat_cnt = CNT_ONE;
    end else begin
      beat_xor = acc_q ^ in_data;
      beat_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end
  end

  // NOTE: every signal this block writes gets its hold value first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_xor_d    = out_xor_q;
    out_parity_d = out_parity_q;
    out_beats_d  = out_beats_q;

    if (accept) begin
      if (in_last) begin
        out_valid_d  = 1'b1;
        out_xor_d    = beat_xor;
        out_parity_d = (^beat_xor) ^ ODD_BIT;
        out_beats_d  = beat_cnt;
        acc_d        = '0;
        cnt_d        = '0;
        state_d      = IDLE;
      end else begin
        acc_d   = beat_xor;
        cnt_d   = beat_cnt;
        state_d = ACC;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_xor_q    <= '0;
      out_parity_q <= ODD_BIT;
      out_beats_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_xor_q    <= out_xor_d;
      out_parity_q <= out_parity_d;
      out_beats_q  <= out_beats_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_xor    = out_xor_q;
  assign out_parity = out_parity_q;
  assign out_beats  = out_beats_q;

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Bench for xor_frame_accumulator. Instance a: WIDTH=8, ODD=0, CNT_W=8.
// Instance b: WIDTH=8, ODD=1, CNT_W=2 (odd parity and count saturation).
// Stimulus pushes hand-computed frame results into per-instance queues;
// monitors pop and compare whenever a result transfers.
module tb_xor_frame_accumulator;

  typedef struct packed {
    logic [7:0] x;
    logic       p;
    logic [7:0] beats;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid_a = 1'b0, in_last_a = 1'b0, out_ready_a = 1'b1;
  logic [7:0] in_data_a = '0;
  logic       in_ready_a, out_valid_a, out_parity_a;
  logic [7:0] out_xor_a, out_beats_a;

  logic       in_valid_b = 1'b0, in_last_b = 1'b0, out_ready_b = 1'b1;
  logic [7:0] in_data_b = '0;
  logic       in_ready_b, out_valid_b, out_parity_b;
  logic [7:0] out_xor_b;
  logic [1:0] out_beats_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_frame_accumulator #(.WIDTH(8), .ODD(0), .CNT_W(8)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_data    (in_data_a),
    .in_last    (in_last_a),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready_a),
    .out_xor    (out_xor_a),
    .out_parity (out_parity_a),
    .out_beats  (out_beats_a)
  );

  xor_frame_accumulator #(.WIDTH(8), .ODD(1), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_data    (in_data_b),
    .in_last    (in_last_b),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready_b),
    .out_xor    (out_xor_b),
    .out_parity (out_parity_b),
    .out_beats  (out_beats_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h required no event at %0t", name, act, $time);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there or
  // at the falling edge, never on the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic last);
    int guard = 0;
    if (sel) begin
      in_valid_b = 1'b1; in_data_b = d; in_last_b = last;
    end else begin
      in_valid_a = 1'b1; in_data_a = d; in_last_a = last;
    end
    while (!(sel ? in_ready_b : in_ready_a) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) fail("send_timeout", {24'h0, d});
    tick();
    if (last) check(sel ? "latency_b" : "latency_a", sel ? out_valid_b : out_valid_a, 1);
    if (sel) in_valid_b = 1'b0;
    else     in_valid_a = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) begin
      if (qa.size() == 0) fail("mon_a_unexpected", {24'h0, out_xor_a});
      else begin
        ea = qa.pop_front();
        check("mon_a_xor", out_xor_a, ea.x);
        check("mon_a_parity", out_parity_a, ea.p);
        check("mon_a_beats", out_beats_a, ea.beats);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_b && out_ready_b) begin
      if (qb.size() == 0) fail("mon_b_unexpected", {24'h0, out_xor_b});
      else begin
        eb = qb.pop_front();
        check("mon_b_xor", out_xor_b, eb.x);
        check("mon_b_parity", out_parity_b, eb.p);
        check("mon_b_beats", out_beats_b, eb.beats);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    check("rst_valid_a", out_valid_a, 0);
    check("rst_ready_a", in_ready_a, 1);
    check("rst_xor_a", out_xor_a, 8'h00);
    check("rst_parity_a", out_parity_a, 0);
    check("rst_beats_a", out_beats_a, 0);
    check("rst_parity_b", out_parity_b, 1);
    rst_n = 1'b1;
    tick();

    // Three-beat frame: 0F ^ F0 ^ 3C = C3, four ones -> even parity 0.
    qa.push_back('{x: 8'hC3, p: 1'b0, beats: 8'd3});
    send(0, 8'h0F, 0);
    send(0, 8'hF0, 0);
    send(0, 8'h3C, 1);
    tick();
    check("drain_valid_a", out_valid_a, 0);

    // Single-beat frames, even and odd parity.
    qa.push_back('{x: 8'h01, p: 1'b1, beats: 8'd1});
    send(0, 8'h01, 1);
    qb.push_back('{x: 8'h01, p: 1'b0, beats: 8'd1});
    send(1, 8'h01, 1);
    tick();

    // Gap inside a frame: 12 ^ 34 = 26, three ones -> parity 1.
    send(0, 8'h12, 0);
    repeat (2) tick();
    qa.push_back('{x: 8'h26, p: 1'b1, beats: 8'd2});
    send(0, 8'h34, 1);
    tick();

    // Stalled sink: 55 is held while AA waits on the input.
    out_ready_a = 1'b0;
    qa.push_back('{x: 8'h55, p: 1'b0, beats: 8'd1});
    send(0, 8'h55, 1);
    in_valid_a = 1'b1; in_data_a = 8'hAA; in_last_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_ready_a", in_ready_a, 0);
      check("hold_valid_a", out_valid_a, 1);
      check("hold_xor_a", out_xor_a, 8'h55);
      check("hold_beats_a", out_beats_a, 1);
    end
    qa.push_back('{x: 8'hAA, p: 1'b0, beats: 8'd1});
    out_ready_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    check("handoff_valid_a", out_valid_a, 1);
    check("handoff_xor_a", out_xor_a, 8'hAA);
    tick();
    check("handoff_drain_a", out_valid_a, 0);

    // Back-to-back single-beat frames 01..08, no bubble.
    for (int i = 1; i <= 8; i++) begin
      qa.push_back('{x: 8'(i), p: ^(8'(i)), beats: 8'd1});
      send(0, 8'(i), 1);
    end
    tick();
    check("b2b_drain_a", out_valid_a, 0);

    // Saturation with CNT_W=2: five FF beats -> FF, count 3, parity 0^1 = 1.
    for (int i = 0; i < 4; i++) send(1, 8'hFF, 0);
    qb.push_back('{x: 8'hFF, p: 1'b1, beats: 8'd3});
    send(1, 8'hFF, 1);
    tick();

    // Reset mid-frame on b and with a pending result on a.
    send(1, 8'hFF, 0);
    send(1, 8'hFF, 0);
    out_ready_a = 1'b0;
    send(0, 8'h77, 1);
    rst_n = 1'b0;
    #2;
    check("rst_drop_valid_a", out_valid_a, 0);
    check("rst_drop_xor_a", out_xor_a, 8'h00);
    check("rst_mid_valid_b", out_valid_b, 0);
    tick();
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    tick();
    qb.push_back('{x: 8'h11, p: 1'b1, beats: 8'd1});
    send(1, 8'h11, 1);
    repeat (3) tick();

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_frame_accumulator.md
Name: xor_frame_accumulator

Overview:
- Parametrised, clocked successor to the team's single-bit XOR gate.
- Accepts a stream of WIDTH-bit beats over a valid/ready handshake.
- Computes the bitwise XOR of all beats in a frame delimited by in_last, plus a reduced parity bit and a beat count.
- Presents the result on a registered valid/ready output. Sits between a data source and downstream integrity-check or scrambler logic.

Parameters:
WIDTH, 8, data beat width in bits (>=1)
ODD, 0, parity sense: 0 = even parity (out_parity = XOR-reduce), 1 = odd parity (XNOR-reduce)
CNT_W, 8, width of the beat counter (>=1); count saturates at 2^CNT_W-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  source has a beat
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH  beat data
in_last  input  1  beat is the final beat of its frame
out_valid  output  1  frame result available
out_ready  input  1  sink accepts result
out_xor  output  WIDTH  bitwise XOR of all beats in the frame
out_parity  output  1  XOR-reduce of out_xor, inverted when ODD=1
out_beats  output  CNT_W  beats in frame, saturating

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_xor=0, out_parity=ODD, out_beats=0, accumulator=0, beat counter=0, state=IDLE. in_ready=1 while out_valid=0.
- Accept: a beat transfers when in_valid && in_ready on a rising edge.
- in_ready is combinational: in_ready = !(out_valid && !out_ready).
- FSM states:
  - IDLE (no frame in progress).
  - ACC (frame in progress).
- IDLE + accepted beat, in_last=0: acc <= in_data; cnt <= 1; go to ACC.
- ACC + accepted beat, in_last=0: acc <= acc ^ in_data; cnt <= sat(cnt+1); stay in ACC.
- Accepted beat with in_last=1, either state:
  - final = (IDLE ? in_data : acc ^ in_data); finalcnt = (IDLE ? 1 : sat(cnt+1)).
  - Next edge: out_xor <= final; out_parity <= ^final ^ ODD; out_beats <= finalcnt; out_valid <= 1.
  - acc <= 0; cnt <= 0; state <= IDLE.
- Latency: result is valid exactly 1 cycle after the last beat is accepted. Single-beat frames are legal.
- Output hold: while out_valid && !out_ready, all out_* stay stable and in_ready=0. No beat is lost or consumed.
- Drain: out_valid && out_ready clears out_valid next edge, unless a new final beat is accepted on the same edge; then out_valid stays 1 with the new result.
  - This gives back-to-back single-beat frames at 1 result/cycle with out_ready held high.
- Idle source: in_valid=0 leaves acc, cnt and state unchanged. Gaps inside a frame are allowed.
- Saturation: cnt stops at 2^CNT_W-1; the XOR keeps accumulating.
- Reset mid-frame: the partial frame is discarded, and a pending output is dropped.
- Inputs other than in_valid and out_ready are don't-care when their valid qualifier is low.
- out_* reflect registers only; there is no combinational path from in_* to out_*.

Test Plan:
- Reset, WIDTH=8, ODD=0 -> out_valid=0, in_ready=1, out_xor=0x00, out_parity=0, out_beats=0.
- Beats 0x0F, 0xF0, 0x3C(last), out_ready=1 -> one cycle after the last beat: out_valid=1, out_xor=0xC3, out_parity=0, out_beats=3; out_valid=0 the cycle after.
- Single beat 0x01 with in_last -> out_xor=0x01, out_parity=1, out_beats=1. Same stimulus with ODD=1 -> out_parity=0.
- Result pending, out_ready=0 for 4 cycles while the source holds in_valid=1 with 0xAA -> in_ready=0 and outputs stable. out_ready=1 -> 0xAA is accepted on that edge and no data is lost.
- out_ready=1, eight consecutive single-beat frames 0x01..0x08 -> out_valid high 8 consecutive cycles, out_xor follows 0x01..0x08 with no bubble.
- CNT_W=2, 5-beat frame of 0xFF -> out_beats=3 (saturated), out_xor=0xFF. rst_n pulsed low after the 2nd beat of a new frame, then 0x11(last) -> out_xor=0x11, out_beats=1.
